// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot grant
module rr_arbiter #(
    parameter int ORDER = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [2**ORDER-1:0]   req,
    input  logic                  done,
    output logic [2**ORDER-1:0]   grant,
    output logic [ORDER-1:0]      index,
    output logic                  busy
);
    localparam int N = 2**ORDER;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [N-1:0]     grant_n, cand, masked;
    logic [ORDER-1:0] index_n, ptr, ptr_n, sel;
    logic             busy_n, found, drop;

    // The holder's own bit is excluded so a releasing holder cannot re-win;
    // in IDLE grant is zero and cand is simply req.
    always_comb begin
        cand   = req & ~grant;
        masked = '0;
        sel    = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            masked[i] = cand[i] && (i > int'(ptr));
        end
        for (int i = 0; i < N; i++) begin
            if (masked[i] && !found) begin
                sel   = ORDER'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (cand[i] && !found) begin
                sel   = ORDER'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        index_n = index;
        busy_n  = busy;
        ptr_n   = ptr;
        drop    = done || !req[index];
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_n = {{(N-1){1'b0}}, 1'b1} << sel;
                    index_n = sel;
                    ptr_n   = sel;
                    busy_n  = 1'b1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (drop) begin
                    if (|cand) begin
                        grant_n = {{(N-1){1'b0}}, 1'b1} << sel;
                        index_n = sel;
                        ptr_n   = sel;
                    end else begin
                        grant_n = '0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            index <= '0;
            busy  <= 1'b0;
            ptr   <= ORDER'(N-1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            index <= index_n;
            busy  <= busy_n;
            ptr   <= ptr_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - self-checking bench for rr_arbiter
module tb_rr_arbiter;
    localparam int ORDER = 2;
    localparam int N     = 4;

    logic             clock;
    logic             reset_n;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [ORDER-1:0] index;
    logic             busy;

    int compared   = 0;
    int mismatched = 0;
    int m_owner    = -1;
    int m_ptr      = N-1;

    rr_arbiter #(.ORDER(ORDER)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .index   (index),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rotating search starting just after p, wrapping round once.
    function automatic int pick(input logic [31:0] vec, input int p);
        for (int k = 1; k <= N; k++) begin
            if (vec[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [31:0] c;
        if (!reset_n) begin
            m_owner = -1;
            m_ptr   = N-1;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                m_owner = pick(32'(req), m_ptr);
                m_ptr   = m_owner;
            end
        end else if (done || !req[m_owner]) begin
            c = 32'(req) & ~(32'd1 << m_owner);
            if (c != 0) begin
                m_owner = pick(c, m_owner);
                m_ptr   = m_owner;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("grant", 32'(grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        check("ptr", 32'(dut.ptr), 32'(m_ptr));
        if (m_owner >= 0) check("index", 32'(index), 32'(m_owner));
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;

        // 1: reset, single request, release
        tick();
        tick();
        check("t1_reset_grant", 32'(grant), 32'd0);
        check("t1_reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        req = 4'b0100;
        tick();
        check("t1_grant", 32'(grant), 32'b0100);
        check("t1_index", 32'(index), 32'd2);
        done = 1'b1; req = 4'b0000;
        tick();
        check("t1_idle", 32'(grant), 32'd0);
        done = 1'b0;

        // 2: rotation with all requesting, from fresh reset
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req = 4'b1111;
        tick();
        check("t2_first", 32'(grant), 32'b0001);
        done = 1'b1;
        tick(); check("t2_g1", 32'(grant), 32'b0010);
        tick(); check("t2_g2", 32'(grant), 32'b0100);
        tick(); check("t2_g3", 32'(grant), 32'b1000);
        tick(); check("t2_g4", 32'(grant), 32'b0001);
        check("t2_busy", 32'(busy), 32'd1);

        // 3: wrap-around after 1000 released
        req = 4'b1000;
        tick(); check("t3_g3", 32'(grant), 32'b1000);
        req = 4'b0000;
        tick(); check("t3_idle", 32'(busy), 32'd0);
        done = 1'b0; req = 4'b0011;
        tick(); check("t3_fallback", 32'(grant), 32'b0001);
        done = 1'b1;
        tick(); check("t3_next", 32'(grant), 32'b0010);
        done = 1'b0;

        // 4: holder withdrawal
        req = 4'b0110;
        tick(); check("t4_hold", 32'(grant), 32'b0010);
        req = 4'b0100;
        tick();
        check("t4_grant", 32'(grant), 32'b0100);
        check("t4_index", 32'(index), 32'd2);

        // 5: hold stability while others toggle
        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick(); check("t5_grant", 32'(grant), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            req = {3'($urandom), 1'b1};
            tick();
            check("t5_stable", 32'(grant), 32'b0001);
            check("t5_ptr", 32'(dut.ptr), 32'd0);
        end

        // 6: reset mid-grant
        req = 4'b1000; done = 1'b1;
        tick(); check("t6_g3", 32'(grant), 32'b1000);
        done = 1'b0; req = 4'b1111;
        tick();
        reset_n = 1'b0;
        tick();
        check("t6_rst_grant", 32'(grant), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick(); check("t6_after", 32'(grant), 32'b0001);

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            req = 4'($urandom);
            if (m_owner >= 0 && ($urandom % 4) != 0) req[m_owner] = 1'b1;
            done    = (($urandom % 3) == 0);
            reset_n = (($urandom % 100) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one resource among N = 2**ORDER requesters.
- Priority selection uses trailing-zero counting:
  - the request vector is masked to the positions above the last winner;
  - the lowest set bit of that masked vector wins;
  - if the masked vector is empty, the lowest set bit of the unmasked vector wins.
- Grant is registered and held until the holder releases.
- Sits in front of any shared datapath unit (bus port, memory port, shared ALU) that serves one requester at a time.

Parameters:
- ORDER, default 2: log2 of the requester count; N = 2**ORDER; legal range 1..5.

Ports:
- clock    input   1        rising-edge clock, the only clock.
- reset_n  input   1        synchronous reset, active-low.
- req      input   N        request vector, one bit per requester, level-sensitive.
- done     input   1        single-cycle pulse from the current holder: release the resource.
- grant    output  N        one-hot grant, registered; all-zero when idle.
- index    output  ORDER    binary index of the current holder; valid only while busy = 1.
- busy     output  1        1 while a grant is active.

Behaviour:
- Reset: sampled on a rising clock edge with reset_n = 0. Results:
  - grant = 0, index = 0, busy = 0, state = IDLE;
  - last-winner pointer ptr = N-1, so requester 0 has first priority.
  - Reset overrides everything, including an active grant mid-operation.
- Selection (combinational):
  - mask = bits strictly above ptr, i.e. positions ptr+1..N-1.
  - Candidate A = lowest set bit of req & mask. Candidate B = lowest set bit of req.
  - Pick A if req & mask is nonzero, else B. This gives wrap-around from N-1 back to 0.
  - With ptr = N-1 the mask is empty, so selection is plain lowest-index.
- States: IDLE, GRANT.
- IDLE:
  - req = 0: stay in IDLE.
  - req != 0: on the next edge, grant = one-hot(sel), index = sel, busy = 1, ptr = sel, go to GRANT.
  - Latency from req rising to grant is exactly 1 cycle.
- GRANT:
  - Release condition: done = 1, or req[index] = 0 (holder withdrew).
  - No release: grant, index and ptr are held unchanged, whatever the other req bits do.
  - Release with (req & ~grant) != 0: back-to-back handover on the same edge.
    - New winner is chosen by the rule above, using the updated ptr = index, with the holder's own bit excluded.
    - grant, index and ptr are updated; busy stays 1; no idle bubble.
  - Release with no other requester: grant = 0, busy = 0, go to IDLE; ptr keeps the last winner.
- done while IDLE: ignored.
- Simultaneous done and a new request from the holder itself: the holder does not win again if any other requester is pending. If it is the only requester, it loses the grant for that cycle, returns to IDLE, and is re-granted 1 cycle later.
- Invariants:
  - grant is always zero or one-hot;
  - busy = |grant;
  - index equals the encoding of grant whenever busy = 1.
- Fairness: any continuously asserted request is granted within N-1 grant tenures.
- All outputs are registered; no combinational path from req or done to any output.

Test Plan (ORDER = 2, N = 4):
1. Reset then single request:
   - stimulus: reset_n low 2 cycles, release; req = 4'b0100 held.
   - required: 1 cycle later grant = 0100, index = 2, busy = 1.
   - then done pulse with req = 0 → next cycle grant = 0000, busy = 0.
2. Rotation, all requesting:
   - stimulus: req = 1111; pulse done one cycle after each new grant.
   - required grant sequence: 0001, 0010, 0100, 1000, 0001, with busy staying 1 throughout.
3. Wrap-around masking:
   - stimulus: after 1000 is granted and released, req = 0011.
   - required: next grant 0001 (fallback path), then 0010 after done.
4. Holder withdrawal:
   - stimulus: 0010 granted, req changes 0110 → 0100 with no done.
   - required: next edge grant = 0100, index = 2.
5. Hold stability:
   - stimulus: grant 0001 active; other req bits toggle for 5 cycles; no done.
   - required: grant stays 0001 and ptr is unchanged.
6. Reset mid-grant:
   - stimulus: grant 1000 active; reset_n = 0 for 1 cycle; req = 1111 during and after.
   - required: during reset grant = 0, busy = 0; first grant after reset is 0001 (ptr restored to N-1).
